spi_reg_slave: RTL and testbench

- SPI mode-0 target, MSB first; converts host SPI frames into single-cycle register-bus strobes for the control register file (SD controller, clock divider, reset registers).
- Responder end of the host-side SPI master link; sits between the top-level SS/SCLK/MOSI/MISO pins and the register decode.
- Whole block runs in the pclk_i domain; SPI pins are oversampled.

---
 rtl/spi_reg_slave.sv | 223 ++++++++++++++++++++++
 tb/tb_spi_reg_slave.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_slave.sv
// SPI mode-0 target that turns host frames (SYNC, ADDR, DATA[, TRAIL]) into single-cycle register strobes.
// Define SPI_REG_SLAVE_ERRCNT_EN to build the saturating frame error counter on err_cnt_o.
module spi_reg_slave #(
    parameter logic [7:0] SYNC_BYTE   = 8'h89,
    parameter int         ADDR_W      = 7,
    parameter int         SYNC_STAGES = 2
) (
    input  logic              pclk_i,
    input  logic              rst_i,
    input  logic              spi_ss_i,
    input  logic              spi_sck_i,
    input  logic              spi_mosi_i,
    output logic              spi_miso_o,
    output logic              spi_miso_oe_o,
    output logic [ADDR_W-1:0] reg_addr_o,
    output logic [7:0]        reg_wdata_o,
    output logic              reg_we_o,
    output logic              reg_re_o,
    input  logic [7:0]        reg_rdata_i,
    output logic [7:0]        err_cnt_o
);

    typedef enum logic [2:0] {
        WAIT_IDLE = 3'd0,
        IDLE      = 3'd1,
        SYNC      = 3'd2,
        ADDR      = 3'd3,
        DATA_W    = 3'd4,
        DATA_R    = 3'd5,
        TRAIL     = 3'd6,
        ABORT     = 3'd7
    } state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] ss_sync_q, sck_sync_q, mosi_sync_q;
    logic                   ss_s, sck_s, mosi_s;
    logic                   sck_prev_q;
    logic                   sck_rise, sck_fall;

    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [6:0]        rx_q, rx_d;
    logic [7:0]        rx_byte;
    logic              byte_done;
    logic [6:0]        tx_q, tx_d;
    logic              miso_q, miso_d;
    logic              cap_q, cap_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              re_q, re_d;

    assign ss_s   = ss_sync_q[SYNC_STAGES-1];
    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign sck_rise  = sck_s & ~sck_prev_q;
    assign sck_fall  = ~sck_s & sck_prev_q;
    assign rx_byte   = {rx_q, mosi_s};
    assign byte_done = sck_rise && (bit_cnt_q == 3'd7);

    // SS resets to "selected" so that leaving WAIT_IDLE needs a genuine SS high from the pin.
    always_ff @(posedge pclk_i) begin
        if (rst_i) begin
            ss_sync_q   <= '0;
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
        end else begin
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], spi_ss_i};
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
            sck_prev_q  <= sck_s;
        end
    end

    always_ff @(posedge pclk_i) begin
        if (rst_i) begin
            state_q <= WAIT_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (ss_s) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                WAIT_IDLE: state_d = WAIT_IDLE;
                IDLE:      state_d = SYNC;
                SYNC: begin
                    if (byte_done) state_d = (rx_byte == SYNC_BYTE) ? ADDR : ABORT;
                end
                ADDR: begin
                    if (byte_done) state_d = rx_byte[7] ? DATA_W : DATA_R;
                end
                DATA_W: begin
                    if (byte_done) state_d = TRAIL;
                end
                DATA_R: begin
                    if (byte_done) state_d = SYNC;
                end
                TRAIL: begin
                    if (byte_done) state_d = SYNC;
                end
                ABORT:   state_d = ABORT;
                default: state_d = WAIT_IDLE;
            endcase
        end
    end

    // SS high outranks a byte completing in the same cycle, so no strobe comes from a cut-off byte.
    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        re_d    = 1'b0;
        if (!ss_s && byte_done) begin
            case (state_q)
                ADDR: begin
                    addr_d = rx_byte[ADDR_W-1:0];
                    re_d   = ~rx_byte[7];
                end
                DATA_W: begin
                    wdata_d = rx_byte;
                    we_d    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // The fall right after the address byte is not a shift: the MSB must stay up for the first DATA_R rise.
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        miso_d    = miso_q;
        cap_d     = re_q;
        if (ss_s) begin
            bit_cnt_d = 3'd0;
        end else if (sck_rise && state_q != WAIT_IDLE) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
        end
        if (sck_rise) begin
            rx_d = rx_byte[6:0];
        end
        if (ss_s || state_q != DATA_R) begin
            miso_d = 1'b0;
        end else if (cap_q) begin
            miso_d = reg_rdata_i[7];
            tx_d   = reg_rdata_i[6:0];
        end else if (sck_fall && bit_cnt_q != 3'd0) begin
            miso_d = tx_q[6];
            tx_d   = {tx_q[5:0], 1'b0};
        end
    end

    always_ff @(posedge pclk_i) begin
        if (rst_i) begin
            bit_cnt_q <= 3'd0;
            rx_q      <= '0;
            tx_q      <= '0;
            miso_q    <= 1'b0;
            cap_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            re_q      <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            miso_q    <= miso_d;
            cap_q     <= cap_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            re_q      <= re_d;
        end
    end

    assign spi_miso_o    = miso_q;
    assign spi_miso_oe_o = ~ss_s & (state_q != WAIT_IDLE);
    assign reg_addr_o    = addr_q;
    assign reg_wdata_o   = wdata_q;
    assign reg_we_o      = we_q;
    assign reg_re_o      = re_q;

`ifdef SPI_REG_SLAVE_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       err_inc;

    // Errors: a bad sync byte, or the host deselecting before the data byte of a frame has completed.
    always_comb begin
        err_inc = 1'b0;
        if (ss_s) begin
            err_inc = (state_q == ADDR) || (state_q == DATA_W) || (state_q == DATA_R);
        end else if (byte_done && state_q == SYNC && rx_byte != SYNC_BYTE) begin
            err_inc = 1'b1;
        end
        err_cnt_d = err_cnt_q;
        if (err_inc && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge pclk_i) begin
        if (rst_i) begin
            err_cnt_q <= 8'h00;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt_o = err_cnt_q;
`else
    assign err_cnt_o = 8'h00;
`endif

endmodule

// File: tb/tb_spi_reg_slave.sv
// Bench for spi_reg_slave: table of frames with fixed expectations, hand-written corner sequences,
// then random frames checked against a frame-level parsing model.
module tb_spi_reg_slave;

    localparam int HALF = 5;
    localparam logic [7:0] SYNC = 8'h89;

    logic       pclk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       spi_ss_i = 1'b1;
    logic       spi_sck_i = 1'b0;
    logic       spi_mosi_i = 1'b0;
    logic       spi_miso_o, spi_miso_oe_o;
    logic [6:0] reg_addr_o;
    logic [7:0] reg_wdata_o;
    logic       reg_we_o, reg_re_o;
    logic [7:0] reg_rdata_i = 8'h00;
    logic [7:0] err_cnt_o;

    always #5 pclk_i = ~pclk_i;

    spi_reg_slave dut (
        .pclk_i        (pclk_i),
        .rst_i         (rst_i),
        .spi_ss_i      (spi_ss_i),
        .spi_sck_i     (spi_sck_i),
        .spi_mosi_i    (spi_mosi_i),
        .spi_miso_o    (spi_miso_o),
        .spi_miso_oe_o (spi_miso_oe_o),
        .reg_addr_o    (reg_addr_o),
        .reg_wdata_o   (reg_wdata_o),
        .reg_we_o      (reg_we_o),
        .reg_re_o      (reg_re_o),
        .reg_rdata_i   (reg_rdata_i),
        .err_cnt_o     (err_cnt_o)
    );

    int          n_checks = 0;
    int          n_pass = 0;
    int          exp_err = 0;
    logic [7:0]  mem [128];
    logic [14:0] we_log[$];
    logic [6:0]  re_log[$];
    logic [7:0]  rx_q[$];
    logic [7:0]  gen_q[$];
    logic [14:0] exp_w_q[$];
    logic [6:0]  exp_r_q[$];
    logic [7:0]  exp_miso_q[$];
    logic        oe_mid;
    logic        re_prev = 1'b0;
    logic [6:0]  re_addr_prev = 7'h0;

    typedef struct {
        logic [63:0] b;
        int          nb;
        int          part;
        int          n_we;
        logic [14:0] w0;
        logic [14:0] w1;
        int          n_re;
        logic [6:0]  raddr;
        logic [7:0]  miso_last;
        int          err;
        logic [6:0]  addr_after;
    } vec_t;

    vec_t vecs[8];

    function automatic vec_t mk(input logic [63:0] b, input int nb, input int part, input int n_we,
                                input logic [14:0] w0, input logic [14:0] w1, input int n_re,
                                input logic [6:0] raddr, input logic [7:0] miso_last, input int err,
                                input logic [6:0] addr_after);
        vec_t v;
        v.b = b; v.nb = nb; v.part = part; v.n_we = n_we; v.w0 = w0; v.w1 = w1;
        v.n_re = n_re; v.raddr = raddr; v.miso_last = miso_last; v.err = err; v.addr_after = addr_after;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [7:0] err_exp();
`ifdef SPI_REG_SLAVE_ERRCNT_EN
        return exp_err[7:0];
`else
        return 8'h00;
`endif
    endfunction

    task automatic bump_err(input int n);
        exp_err = (exp_err + n > 255) ? 255 : exp_err + n;
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge pclk_i);
    endtask

    // Strobe monitor, sampled on the falling edge.
    initial forever begin
        @(negedge pclk_i);
        if (reg_we_o) we_log.push_back({reg_addr_o, reg_wdata_o});
        if (reg_re_o) re_log.push_back(reg_addr_o);
    end

    // Register file: read data is valid only in the cycle right after reg_re_o, random otherwise.
    initial forever begin
        @(posedge pclk_i);
        #1;
        reg_rdata_i  = re_prev ? mem[re_addr_prev] : 8'($urandom);
        re_prev      = reg_re_o;
        re_addr_prev = reg_addr_o;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic spi_bits(input logic [7:0] b, input int nb, input bit ss_with_last, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nb; i++) begin
            spi_mosi_i = b[7-i];
            clks(HALF);
            rx[7-i] = spi_miso_o;
            spi_sck_i = 1'b1;
            if (ss_with_last && i == nb - 1) spi_ss_i = 1'b1;
            clks(HALF);
            spi_sck_i = 1'b0;
        end
    endtask

    task automatic run_frame(input logic [7:0] bq[$], input int part, input logic [7:0] pb);
        logic [7:0] rx;
        we_log.delete(); re_log.delete(); rx_q.delete();
        spi_ss_i = 1'b0;
        clks(HALF);
        oe_mid = spi_miso_oe_o;
        foreach (bq[i]) begin
            spi_bits(bq[i], 8, 1'b0, rx);
            rx_q.push_back(rx);
        end
        if (part > 0) spi_bits(pb, part, 1'b0, rx);
        clks(HALF);
        spi_ss_i = 1'b1;
        clks(3 * HALF);
    endtask

    // Frame-level model: walk the byte list as a sequence of transactions.
    task automatic model_frame(input logic [7:0] b[$]);
        int pos = 0;
        int n;
        logic [7:0] a;
        n = b.size();
        exp_w_q.delete(); exp_r_q.delete(); exp_miso_q.delete();
        for (int i = 0; i < n; i++) exp_miso_q.push_back(8'h00);
        while (pos < n) begin
            if (b[pos] != SYNC) begin bump_err(1); break; end
            if (pos + 1 >= n) begin bump_err(1); break; end
            a = b[pos+1];
            if (a[7]) begin
                if (pos + 2 >= n) begin bump_err(1); break; end
                exp_w_q.push_back({a[6:0], b[pos+2]});
                pos += 4;
            end else begin
                exp_r_q.push_back(a[6:0]);
                if (pos + 2 >= n) begin bump_err(1); break; end
                exp_miso_q[pos+2] = mem[a[6:0]];
                pos += 3;
            end
        end
    endtask

    task automatic rand_frame(output int part, output logic [7:0] pb);
        int ntx, cut;
        logic [7:0] s, a;
        gen_q.delete();
        ntx = $urandom_range(1, 3);
        for (int t = 0; t < ntx; t++) begin
            a = 8'($urandom_range(0, 127));
            s = SYNC;
            if ($urandom_range(0, 7) == 0) begin
                s = 8'($urandom_range(0, 255));
                if (s == SYNC) s = 8'h88;
            end
            gen_q.push_back(s);
            if ($urandom_range(0, 1) == 1) begin
                gen_q.push_back(a | 8'h80);
                gen_q.push_back(8'($urandom));
                gen_q.push_back(8'($urandom));
            end else begin
                gen_q.push_back(a);
                gen_q.push_back(8'($urandom));
            end
        end
        part = 0;
        if ($urandom_range(0, 3) == 0) begin
            cut = $urandom_range(1, gen_q.size() - 1);
            while (gen_q.size() > cut) void'(gen_q.pop_back());
            part = $urandom_range(0, 7);
        end
        pb = 8'($urandom);
    endtask

    task automatic compare_model(input int k);
        check($sformatf("rnd%0d we_count", k), we_log.size(), exp_w_q.size());
        for (int i = 0; i < we_log.size() && i < exp_w_q.size(); i++)
            check($sformatf("rnd%0d we[%0d]", k, i), we_log[i], exp_w_q[i]);
        check($sformatf("rnd%0d re_count", k), re_log.size(), exp_r_q.size());
        for (int i = 0; i < re_log.size() && i < exp_r_q.size(); i++)
            check($sformatf("rnd%0d re[%0d]", k, i), re_log[i], exp_r_q[i]);
        for (int i = 0; i < rx_q.size() && i < exp_miso_q.size(); i++)
            check($sformatf("rnd%0d miso[%0d]", k, i), rx_q[i], exp_miso_q[i]);
        check($sformatf("rnd%0d err_cnt", k), err_cnt_o, err_exp());
    endtask

    initial begin
        vec_t       v;
        logic [7:0] rx;
        int         part;
        logic [7:0] pb;

        for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
        mem[7'h24] = 8'h23;
        mem[7'h40] = 8'hC3;

        vecs[0] = mk(64'h89A4230000000000, 4, 0, 1, {7'h24, 8'h23}, 15'h0, 0, 7'h00, 8'h00, 0, 7'h24);
        vecs[1] = mk(64'h8924000000000000, 3, 0, 0, 15'h0, 15'h0, 1, 7'h24, 8'h23, 0, 7'h24);
        vecs[2] = mk(64'h55A4230000000000, 4, 0, 0, 15'h0, 15'h0, 0, 7'h00, 8'h00, 1, 7'h24);
        vecs[3] = mk(64'h8985110000000000, 4, 0, 1, {7'h05, 8'h11}, 15'h0, 0, 7'h00, 8'h00, 0, 7'h05);
        vecs[4] = mk(64'h8985000000000000, 2, 4, 0, 15'h0, 15'h0, 0, 7'h00, 8'h00, 1, 7'h05);
        vecs[5] = mk(64'h8985020089840A00, 8, 0, 2, {7'h05, 8'h02}, {7'h04, 8'h0A}, 0, 7'h00, 8'h00, 0, 7'h04);
        vecs[6] = mk(64'h89C05A008940FF00, 7, 0, 1, {7'h40, 8'h5A}, 15'h0, 1, 7'h40, 8'hC3, 0, 7'h40);
        vecs[7] = mk(64'h8933000000000000, 2, 3, 0, 15'h0, 15'h0, 1, 7'h33, 8'h00, 1, 7'h33);

        rst_i = 1'b1;
        clks(4);
        check("rst miso", spi_miso_o, 0);
        check("rst oe", spi_miso_oe_o, 0);
        check("rst addr", reg_addr_o, 0);
        check("rst wdata", reg_wdata_o, 0);
        check("rst we", reg_we_o, 0);
        check("rst re", reg_re_o, 0);
        check("rst err", err_cnt_o, 0);
        rst_i = 1'b0;
        clks(6);
        check("idle oe", spi_miso_oe_o, 0);

        for (int k = 0; k < 8; k++) begin
            v = vecs[k];
            gen_q.delete();
            for (int i = 0; i < v.nb; i++) gen_q.push_back(v.b[63-8*i -: 8]);
            run_frame(gen_q, v.part, 8'h5A);
            bump_err(v.err);
            check($sformatf("vec%0d oe_selected", k), oe_mid, 1);
            check($sformatf("vec%0d oe_released", k), spi_miso_oe_o, 0);
            check($sformatf("vec%0d we_count", k), we_log.size(), v.n_we);
            if (v.n_we >= 1 && we_log.size() >= 1) check($sformatf("vec%0d we0", k), we_log[0], v.w0);
            if (v.n_we >= 2 && we_log.size() >= 2) check($sformatf("vec%0d we1", k), we_log[1], v.w1);
            check($sformatf("vec%0d re_count", k), re_log.size(), v.n_re);
            if (v.n_re >= 1 && re_log.size() >= 1) check($sformatf("vec%0d re_addr", k), re_log[0], v.raddr);
            for (int i = 0; i < rx_q.size(); i++)
                check($sformatf("vec%0d miso[%0d]", k, i), rx_q[i], (i == v.nb - 1) ? v.miso_last : 8'h00);
            check($sformatf("vec%0d addr_held", k), reg_addr_o, v.addr_after);
            check($sformatf("vec%0d err_cnt", k), err_cnt_o, err_exp());
        end

        // SS rises on the same synchronised cycle as the 8th rise of the data byte.
        we_log.delete(); re_log.delete();
        spi_ss_i = 1'b0;
        clks(HALF);
        spi_bits(SYNC, 8, 1'b0, rx);
        spi_bits(8'h85, 8, 1'b0, rx);
        spi_bits(8'h3C, 8, 1'b1, rx);
        clks(3 * HALF);
        bump_err(1);
        check("coincide we_count", we_log.size(), 0);
        check("coincide addr", reg_addr_o, 7'h05);
        check("coincide err_cnt", err_cnt_o, err_exp());

        // Reset in the middle of the address byte, rest of the frame must be ignored.
        we_log.delete(); re_log.delete();
        spi_ss_i = 1'b0;
        clks(HALF);
        spi_bits(SYNC, 8, 1'b0, rx);
        spi_bits(8'hA4, 3, 1'b0, rx);
        rst_i = 1'b1;
        clks(2);
        rst_i = 1'b0;
        exp_err = 0;
        check("midrst addr", reg_addr_o, 0);
        check("midrst wdata", reg_wdata_o, 0);
        check("midrst we", reg_we_o, 0);
        check("midrst re", reg_re_o, 0);
        check("midrst miso", spi_miso_o, 0);
        check("midrst oe", spi_miso_oe_o, 0);
        check("midrst err", err_cnt_o, 0);
        spi_bits(8'hA4 << 3, 5, 1'b0, rx);
        spi_bits(8'h23, 8, 1'b0, rx);
        spi_bits(8'h00, 8, 1'b0, rx);
        clks(HALF);
        spi_ss_i = 1'b1;
        clks(3 * HALF);
        check("midrst tail we_count", we_log.size(), 0);
        check("midrst tail re_count", re_log.size(), 0);
        gen_q = '{8'h89, 8'h8A, 8'h66, 8'h00};
        run_frame(gen_q, 0, 8'h00);
        check("postrst we_count", we_log.size(), 1);
        if (we_log.size() >= 1) check("postrst we0", we_log[0], {7'h0A, 8'h66});
        check("postrst err", err_cnt_o, err_exp());

        for (int k = 0; k < 25; k++) begin
            rand_frame(part, pb);
            model_frame(gen_q);
            run_frame(gen_q, part, pb);
            compare_model(k);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
